// File: rtl/johnson_counter_ctrl.sv
// johnson_counter_ctrl: valid/ready command sequencer for an external
// WIDTH-bit Johnson counter with preset. It drives the counter's clear,
// preset and load pins and watches its count output.
// Build option: define JC_CTRL_LEGAL_CHECK_EN to add the illegal-word
// check (FAULT state and the sticky fault flag). Without it, fault is 0.
module johnson_counter_ctrl #(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [WIDTH-1:0]  cmd_pattern,
  input  logic [STEP_W-1:0] cmd_steps,
  output logic              cnt_clear_n,
  output logic              cnt_preset_n,
  output logic [WIDTH-1:0]  cnt_load,
  input  logic [WIDTH-1:0]  cnt_count,
  output logic              busy,
  output logic              done,
  output logic              fault
);

  typedef enum logic [2:0] {
    ST_CLR   = 3'd0,
    ST_IDLE  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_RUN   = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_RUN   = 2'b01;
  localparam logic [1:0] OP_HOLD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  state_e             state_q, state_d;
  logic [STEP_W-1:0]  remaining_q, remaining_d;
  logic [WIDTH-1:0]   pat_q, pat_d;
  logic               done_q, done_d;
  // Set when CLR was entered from a CLEAR command, so its exit reports done.
  logic               clr_cmd_q, clr_cmd_d;
  logic               accept;

`ifdef JC_CTRL_LEGAL_CHECK_EN
  logic               fault_q, fault_d;

  // A Johnson word, viewed as a ring, has either no edges or exactly two.
  function automatic logic is_legal(input logic [WIDTH-1:0] w);
    int unsigned n;
    n = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (w[i] != w[(i + 1) % WIDTH]) n++;
    end
    return (n == 0) || (n == 2);
  endfunction
`endif

  assign cmd_ready = (state_q == ST_IDLE) || (state_q == ST_RUN);
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;

  // Next-state, step bookkeeping and done/fault generation.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    pat_d       = pat_q;
    done_d      = 1'b0;
    clr_cmd_d   = 1'b0;
`ifdef JC_CTRL_LEGAL_CHECK_EN
    fault_d     = fault_q;
`endif
    case (state_q)
      ST_CLR: begin
        state_d = ST_IDLE;
        done_d  = clr_cmd_q;
      end
      ST_LOAD: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      ST_FAULT: state_d = ST_IDLE;
      ST_IDLE, ST_RUN: begin
        // A run finishes on its last step; an accepted command overrides it.
        if (state_q == ST_RUN) begin
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == STEP_W'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        if (accept) begin
          done_d      = 1'b0;
          remaining_d = '0;
          case (cmd_op)
            OP_LOAD: begin
              pat_d   = cmd_pattern;
              state_d = ST_LOAD;
`ifdef JC_CTRL_LEGAL_CHECK_EN
              if (!is_legal(cmd_pattern)) begin
                state_d = ST_FAULT;
                fault_d = 1'b1;
              end
`endif
            end
            OP_RUN: begin
              if (cmd_steps == '0) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end else begin
                state_d     = ST_RUN;
                remaining_d = cmd_steps;
              end
            end
            OP_HOLD: state_d = ST_IDLE;
            default: begin
              state_d   = ST_CLR;
              clr_cmd_d = 1'b1;
`ifdef JC_CTRL_LEGAL_CHECK_EN
              fault_d   = 1'b0;
`endif
            end
          endcase
        end
`ifdef JC_CTRL_LEGAL_CHECK_EN
        // A corrupted counter overrides anything issued in the same cycle.
        if (!is_legal(cnt_count)) begin
          state_d     = ST_FAULT;
          fault_d     = 1'b1;
          done_d      = 1'b0;
          clr_cmd_d   = 1'b0;
          remaining_d = '0;
        end
`endif
      end
      default: state_d = ST_CLR;
    endcase
  end

  // Counter pin drive; clear also forces the counter clear immediately.
  always_comb begin
    cnt_clear_n  = 1'b1;
    cnt_preset_n = 1'b1;
    cnt_load     = '0;
    case (state_q)
      ST_IDLE: begin
        // Reload the counter's own value so it stays frozen.
        cnt_preset_n = 1'b0;
        cnt_load     = cnt_count;
      end
      ST_LOAD: begin
        cnt_preset_n = 1'b0;
        cnt_load     = pat_q;
      end
      ST_RUN:  cnt_preset_n = 1'b1;
      default: cnt_clear_n  = 1'b0;
    endcase
    if (clear) cnt_clear_n = 1'b0;
  end

  // Controller state registers.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q     <= ST_CLR;
      remaining_q <= '0;
      pat_q       <= '0;
      done_q      <= 1'b0;
      clr_cmd_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      pat_q       <= pat_d;
      done_q      <= done_d;
      clr_cmd_q   <= clr_cmd_d;
    end
  end

`ifdef JC_CTRL_LEGAL_CHECK_EN
  // Sticky fault flag.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) fault_q <= 1'b0;
    else       fault_q <= fault_d;
  end
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_johnson_counter_ctrl.sv
// Bench for johnson_counter_ctrl: includes a behavioural Johnson counter
// with preset driven by the controller's pins. Expected counts are queued
// when a command is issued and checked on each done pulse.
module tb_johnson_counter_ctrl;
  localparam int W  = 4;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          clear = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b10;
  logic [W-1:0]  cmd_pattern = '0;
  logic [SW-1:0] cmd_steps = '0;
  logic          cnt_clear_n, cnt_preset_n;
  logic [W-1:0]  cnt_load, cnt_count;
  logic          busy, done, fault;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] cur;

  johnson_counter_ctrl #(.WIDTH(W), .STEP_W(SW)) dut (
    .clk(clk), .clear(clear), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_pattern(cmd_pattern), .cmd_steps(cmd_steps),
    .cnt_clear_n(cnt_clear_n), .cnt_preset_n(cnt_preset_n), .cnt_load(cnt_load),
    .cnt_count(cnt_count), .busy(busy), .done(done), .fault(fault)
  );

  always #5 clk = ~clk;

  // External Johnson counter: clear, else preset-load, else twisted shift.
  always @(posedge clk) begin
    if (!cnt_clear_n)       cnt_count <= '0;
    else if (!cnt_preset_n) cnt_count <= cnt_load;
    else                    cnt_count <= {cnt_count[W-2:0], ~cnt_count[W-1]};
  end

  function automatic logic [W-1:0] succ(input logic [W-1:0] v, input int n);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[W-2:0], ~r[W-1]};
    return r;
  endfunction

  // Scoreboard: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!clear && done === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL done_unexpected: done=1 with nothing pending, count=%b", cnt_count);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (cnt_count !== e) begin
          n_fail++;
          $display("FAIL done_count: got %b expected %b", cnt_count, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [1:0] op, input logic [W-1:0] pat, input logic [SW-1:0] steps);
    n_tests++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL cmd_ready: got %b expected 1 (op %b)", cmd_ready, op);
    end
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_pattern = pat;
    cmd_steps   = steps;
    @(negedge clk);
    cmd_valid   = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_idle: timeout, pending=%0d busy=%b", exp_q.size(), busy);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    logic held;
    clear = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (cnt_clear_n !== 1'b0) begin
      n_fail++; $display("FAIL reset_clear_n: got %b expected 0", cnt_clear_n);
    end
    clear = 1'b0;
    #1;
    n_tests++;
    if (cnt_clear_n !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_cycle: clear_n=%b busy=%b done=%b fault=%b expected 0 1 0 0",
               cnt_clear_n, busy, done, fault);
    end
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || cnt_clear_n !== 1'b1 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b clear_n=%b ready=%b expected 0 1 1", busy, cnt_clear_n, cmd_ready);
    end
    held = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (cnt_count !== 4'b0000 || busy !== 1'b0) held = 1'b0;
    end
    n_tests++;
    if (!held) begin
      n_fail++; $display("FAIL reset_hold: count=%b busy=%b expected 0000 0", cnt_count, busy);
    end
    cur = 4'b0000;
  endtask

  task automatic test_load_run();
    int n;
    exp_q.push_back(4'b1000);
    issue(2'b00, 4'b1000, 8'd0);
    wait_idle(10);
    n_tests++;
    if (cnt_count !== 4'b1000) begin
      n_fail++; $display("FAIL load_value: got %b expected 1000", cnt_count);
    end
    cur = succ(4'b1000, 5);
    exp_q.push_back(cur);
    issue(2'b01, '0, 8'd5);
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      n++;
      @(negedge clk);
    end
    n_tests++;
    if (n != 5) begin
      n_fail++; $display("FAIL run_length: got %0d busy cycles expected 5", n);
    end
    wait_idle(10);
    repeat (5) @(negedge clk);
    n_tests++;
    if (cnt_count !== cur) begin
      n_fail++; $display("FAIL run_freeze: got %b expected %b", cnt_count, cur);
    end
  endtask

  task automatic test_hold_abort();
    issue(2'b01, '0, 8'd200);
    repeat (6) @(negedge clk);
    issue(2'b10, '0, 8'd0);
    cur = succ(cur, 7);
    n_tests++;
    if (busy !== 1'b0 || cnt_count !== cur) begin
      n_fail++; $display("FAIL hold_abort: busy=%b count=%b expected 0 %b", busy, cnt_count, cur);
    end
    repeat (5) @(negedge clk);
    n_tests++;
    if (cnt_count !== cur) begin
      n_fail++; $display("FAIL hold_freeze: got %b expected %b", cnt_count, cur);
    end
  endtask

  task automatic test_run_zero();
    exp_q.push_back(cur);
    issue(2'b01, '0, 8'd0);
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      n_fail++; $display("FAIL run_zero: busy=%b done=%b expected 0 1", busy, done);
    end
    wait_idle(10);
    // Idle HOLD is a no-op; any done would hit an empty scoreboard.
    issue(2'b10, '0, 8'd0);
    repeat (3) @(negedge clk);
    n_tests++;
    if (cnt_count !== cur) begin
      n_fail++; $display("FAIL run_zero_count: got %b expected %b", cnt_count, cur);
    end
  endtask

  task automatic test_clear_in_run();
    issue(2'b01, '0, 8'd50);
    repeat (3) @(negedge clk);
    exp_q.push_back(4'b0000);
    issue(2'b11, '0, 8'd0);
    wait_idle(10);
    repeat (3) @(negedge clk);
    cur = 4'b0000;
    n_tests++;
    if (cnt_count !== 4'b0000) begin
      n_fail++; $display("FAIL clear_in_run: got %b expected 0000", cnt_count);
    end
  endtask

  task automatic test_back_to_back();
    issue(2'b01, '0, 8'd10);
    @(negedge clk);
    exp_q.push_back(4'b0011);
    issue(2'b00, 4'b0011, 8'd0);
    wait_idle(10);
    cur = succ(4'b0011, 3);
    exp_q.push_back(cur);
    issue(2'b01, '0, 8'd3);
    issue(2'b01, '0, 8'd2);
    wait_idle(20);
    n_tests++;
    if (cnt_count !== cur) begin
      n_fail++; $display("FAIL back_to_back: got %b expected %b", cnt_count, cur);
    end
  endtask

  task automatic test_illegal_load();
`ifdef JC_CTRL_LEGAL_CHECK_EN
    issue(2'b00, 4'b1010, 8'd0);
    n_tests++;
    if (fault !== 1'b1 || cnt_clear_n !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL fault_entry: fault=%b clear_n=%b busy=%b expected 1 0 1", fault, cnt_clear_n, busy);
    end
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || cnt_count !== 4'b0000 || fault !== 1'b1) begin
      n_fail++; $display("FAIL fault_exit: busy=%b count=%b fault=%b expected 0 0000 1", busy, cnt_count, fault);
    end
    exp_q.push_back(4'b0000);
    issue(2'b11, '0, 8'd0);
    wait_idle(10);
    n_tests++;
    if (fault !== 1'b0) begin
      n_fail++; $display("FAIL fault_clear: got %b expected 0", fault);
    end
`else
    exp_q.push_back(4'b1010);
    issue(2'b00, 4'b1010, 8'd0);
    wait_idle(10);
    n_tests++;
    if (cnt_count !== 4'b1010 || fault !== 1'b0) begin
      n_fail++; $display("FAIL illegal_load: count=%b fault=%b expected 1010 0", cnt_count, fault);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_load_run();
    test_hold_abort();
    test_run_zero();
    test_clear_in_run();
    test_back_to_back();
    test_illegal_load();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/johnson_counter_ctrl.md
Name: johnson_counter_ctrl

Overview:
Command-driven sequencer for the WIDTH-bit Johnson counter with preset. It owns the counter's clear, preset and load_cnt pins and observes its count output. It turns a valid/ready command stream into exact counter operations: clear, load a pattern, advance exactly N steps, or hold. It sits between the higher-level timing/phase logic and the counter instance, and reports completion and illegal-state faults.

Parameters:
WIDTH, 4, counter width; must match the driven counter.
STEP_W, 8, width of the RUN step-count operand.

Ports:
clk  in  1  clock; also drives the counter.
clear  in  1  asynchronous active-high reset.
cmd_valid  in  1  command offered.
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising clk.
cmd_op  in  2  00=LOAD, 01=RUN, 10=HOLD, 11=CLEAR.
cmd_pattern  in  WIDTH  LOAD operand.
cmd_steps  in  STEP_W  RUN operand, number of counter advances.
cnt_clear_n  out  1  to counter clear; active-low.
cnt_preset_n  out  1  to counter preset; active-low, loads cnt_load on clk edge.
cnt_load  out  WIDTH  to counter load_cnt.
cnt_count  in  WIDTH  from counter count.
busy  out  1  state != IDLE.
done  out  1  one-cycle pulse when a LOAD, RUN or CLEAR finishes.
fault  out  1  sticky illegal-state flag; see Optional Feature.

Behaviour:
- States: CLR, IDLE, LOAD, RUN, FAULT.
- Reset (clear=1), asynchronous:
  - state=CLR, step counter=0, done=0, fault=0.
  - cnt_clear_n=0 combinationally while clear=1.
- Outputs per state:
  - CLR: cnt_clear_n=0, cnt_preset_n=1, cnt_load=0.
  - IDLE: cnt_clear_n=1, cnt_preset_n=0, cnt_load=cnt_count (combinational). The counter reloads its own value, so it is frozen.
  - LOAD: cnt_preset_n=0, cnt_load=registered pattern.
  - RUN: cnt_preset_n=1, so the counter advances every clk.
  - FAULT: same as CLR.
- cmd_ready=1 in IDLE and RUN; 0 in CLR, LOAD and FAULT.
- Transitions:
  - CLR lasts exactly 1 cycle, then IDLE. done pulses on CLR exit only if CLR was entered by a CLEAR command, not by reset.
  - IDLE + LOAD: register pattern, go to LOAD. LOAD lasts 1 cycle, then IDLE with done. Counter shows the pattern on the cycle after LOAD.
  - IDLE + RUN, steps=N>0: go to RUN with remaining=N. RUN lasts exactly N cycles (remaining decrements each cycle), then IDLE with done. The counter has advanced exactly N positions.
  - IDLE + RUN, steps=0: stay IDLE, done pulses next cycle, no advance.
  - IDLE + HOLD: no-op; done stays 0.
  - IDLE + CLEAR: go to CLR.
  - RUN + HOLD: abort. IDLE next cycle, no done. Advances already taken stand.
  - RUN + CLEAR: CLR next cycle.
  - RUN + LOAD or RUN: preempt. Behaves as if issued from IDLE; no done for the aborted run.
- Step counter is STEP_W-bit; N up to 2^STEP_W-1. No wrap inside a run.
- Reset mid-operation: immediate CLR; any pending run is discarded.

Optional Feature:
Macro JC_CTRL_LEGAL_CHECK_EN.
- Enabled:
  - Legality rule: a WIDTH-bit word is legal iff, viewed cyclically, it has 0 or 2 adjacent-bit transitions.
  - In IDLE or RUN, an illegal cnt_count goes to FAULT next cycle and sets fault=1.
  - A LOAD command with an illegal pattern is accepted but goes to FAULT instead of LOAD.
  - FAULT lasts 1 cycle (counter cleared), then IDLE.
  - fault stays 1 until clear or an accepted CLEAR command.
- Disabled: no check logic; fault tied to 0; FAULT state unreachable.

Test Plan:
- Reset: clear=1 for 2 cycles then 0 -> cnt_clear_n=0 during reset and for 1 CLR cycle; then IDLE, busy=0, count held at 0000 for 20 cycles.
- LOAD 1000, then RUN 5 -> count goes to 1000 on the cycle after LOAD. After exactly 5 advances it freezes at the 5th successor. done pulses once per command.
- RUN 200 then HOLD after 7 cycles -> exactly 7 advances, freeze, no done, busy=0 next cycle.
- RUN 0 -> done pulse, count unchanged. Then CLEAR during a RUN 50 -> count 0000, done on CLR exit.
- With JC_CTRL_LEGAL_CHECK_EN: LOAD 1010 -> FAULT, fault=1, count 0000. Then CLEAR -> fault=0. Without the macro: 1010 loads, fault stays 0.
